// File: rtl/piezo_rx_if.sv
// Pin and result bundle for the piezo tone receiver.
// The slave side belongs to the receiver; the master side drives the pins and reads the results.
interface piezo_rx_if;
    logic        piezo;
    logic        piezo_n;
    logic        note_vld;
    logic [1:0]  note;
    logic [24:0] note_dur;
    logic        tune_vld;
    logic [1:0]  tune;
    logic        diff_err;

    modport master (
        output piezo, piezo_n,
        input  note_vld, note, note_dur, tune_vld, tune, diff_err
    );

    modport slave (
        input  piezo, piezo_n,
        output note_vld, note, note_dur, tune_vld, tune, diff_err
    );
endinterface

// File: rtl/piezo_rx.sv
// Piezo tone receiver: measures the period of the piezo drive, classifies notes G6/C7/E7/G7,
// times each note and recognises the STEER, FAST and BATT alert tunes.
module piezo_rx #(
    parameter int G6_PER  = 31888,
    parameter int C7_PER  = 23889,
    parameter int E7_PER  = 18961,
    parameter int G7_PER  = 15944,
    parameter int TOL     = 256,
    parameter int SIL_LEN = 65535
) (
    input  logic      clk,
    input  logic      rst_n,
    piezo_rx_if.slave bus
);

    typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, TRACK = 2'd2} state_t;

    localparam logic [15:0]        G6_P  = 16'(G6_PER);
    localparam logic [15:0]        C7_P  = 16'(C7_PER);
    localparam logic [15:0]        E7_P  = 16'(E7_PER);
    localparam logic [15:0]        G7_P  = 16'(G7_PER);
    localparam logic [15:0]        SIL_P = 16'(SIL_LEN);
    localparam logic [24:0]        SIL_D = 25'(SIL_LEN);
    localparam logic signed [17:0] TOL_S = 18'(TOL);

    // Oldest note sits in the top bits of the buffer.
    localparam logic [11:0] STEER_PAT = 12'b00_01_10_11_10_11;
    localparam logic [5:0]  FAST_PAT  = 6'b00_01_10;
    localparam logic [11:0] BATT_PAT  = 12'b11_10_11_10_01_00;

    function automatic logic near(input logic [15:0] p, input logic [15:0] nom);
        logic signed [17:0] diff;
        diff = $signed({2'b00, p}) - $signed({2'b00, nom});
        return (diff <= TOL_S) && (diff >= -TOL_S);
    endfunction

    function automatic logic [24:0] sat_inc(input logic [24:0] v);
        return (v == '1) ? v : v + 25'd1;
    endfunction

    state_t      state_q;
    logic        p_s1_q, p_s2_q, p_prev_q, rise_q;
    logic        n_s1_q, n_s2_q, eq_q, diff_err_q;
    logic [15:0] per_q;
    logic        sil_done_q;
    logic [24:0] dur_q;
    logic [1:0]  cur_q;
    logic        note_vld_q;
    logic [1:0]  note_q;
    logic [24:0] note_dur_q;
    logic [11:0] buf_q;
    logic [2:0]  cnt_q;
    logic        eval_q;
    logic        tune_vld_q;
    logic [1:0]  tune_q;

    logic        sil_ev;
    logic        cls_vld_d;
    logic [1:0]  cls_d;
    logic [24:0] dur_inc_d;
    logic        emit_d;
    logic [24:0] emit_dur_d;
    logic [1:0]  tune_d;

    // Silence fires once, in the first cycle the period counter sits at SIL_LEN.
    assign sil_ev    = (per_q == SIL_P) && !sil_done_q && !rise_q;
    assign dur_inc_d = sat_inc(dur_q);

    always_comb begin
        cls_vld_d = 1'b1;
        cls_d     = 2'd0;
        if (near(per_q, G6_P))      cls_d = 2'd0;
        else if (near(per_q, C7_P)) cls_d = 2'd1;
        else if (near(per_q, E7_P)) cls_d = 2'd2;
        else if (near(per_q, G7_P)) cls_d = 2'd3;
        else                        cls_vld_d = 1'b0;
    end

    always_comb begin
        emit_d     = 1'b0;
        emit_dur_d = dur_inc_d;
        if (state_q == TRACK) begin
            if (rise_q) begin
                emit_d = !cls_vld_d || (cls_d != cur_q);
            end else if (sil_ev) begin
                emit_d     = 1'b1;
                emit_dur_d = dur_inc_d - SIL_D;
            end
        end
    end

    always_comb begin
        tune_d = 2'b00;
        if (cnt_q == 3'd6 && buf_q == STEER_PAT)     tune_d = 2'b01;
        else if (cnt_q == 3'd3 && buf_q[5:0] == FAST_PAT) tune_d = 2'b10;
        else if (cnt_q == 3'd6 && buf_q == BATT_PAT) tune_d = 2'b11;
    end

    // The piezo_n synchroniser resets to 1 so the idle pin pair does not look equal.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            p_s1_q     <= 1'b0;
            p_s2_q     <= 1'b0;
            p_prev_q   <= 1'b0;
            rise_q     <= 1'b0;
            n_s1_q     <= 1'b1;
            n_s2_q     <= 1'b1;
            eq_q       <= 1'b0;
            diff_err_q <= 1'b0;
            per_q      <= '0;
            sil_done_q <= 1'b0;
            dur_q      <= '0;
            cur_q      <= '0;
            note_vld_q <= 1'b0;
            note_q     <= '0;
            note_dur_q <= '0;
            buf_q      <= '0;
            cnt_q      <= '0;
            eval_q     <= 1'b0;
            tune_vld_q <= 1'b0;
            tune_q     <= '0;
        end else begin
            p_s1_q   <= bus.piezo;
            p_s2_q   <= p_s1_q;
            p_prev_q <= p_s2_q;
            rise_q   <= p_s2_q & ~p_prev_q;
            n_s1_q   <= bus.piezo_n;
            n_s2_q   <= n_s1_q;
            eq_q     <= (p_s2_q == n_s2_q);
            if (eq_q && (p_s2_q == n_s2_q)) diff_err_q <= 1'b1;

            if (rise_q)              per_q <= 16'd1;
            else if (per_q != SIL_P) per_q <= per_q + 16'd1;
            if (rise_q)      sil_done_q <= 1'b0;
            else if (sil_ev) sil_done_q <= 1'b1;

            note_vld_q <= 1'b0;
            tune_vld_q <= 1'b0;
            eval_q     <= 1'b0;

            case (state_q)
                IDLE: if (rise_q) state_q <= ARM;
                ARM: begin
                    if (rise_q) begin
                        if (cls_vld_d) begin
                            cur_q   <= cls_d;
                            dur_q   <= {9'd0, per_q};
                            state_q <= TRACK;
                        end
                    end else if (sil_ev) begin
                        state_q <= IDLE;
                        eval_q  <= 1'b1;
                    end
                end
                TRACK: begin
                    dur_q <= dur_inc_d;
                    if (rise_q) begin
                        if (!cls_vld_d) begin
                            state_q <= ARM;
                        end else if (cls_d != cur_q) begin
                            cur_q <= cls_d;
                            dur_q <= {9'd0, per_q};
                        end
                    end else if (sil_ev) begin
                        state_q <= IDLE;
                        eval_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (emit_d) begin
                note_vld_q <= 1'b1;
                note_q     <= cur_q;
                note_dur_q <= emit_dur_d;
                buf_q      <= {buf_q[9:0], cur_q};
                cnt_q      <= (cnt_q == 3'd7) ? cnt_q : cnt_q + 3'd1;
            end

            // Evaluated one cycle after silence so the closing note is already buffered.
            if (eval_q) begin
                if (cnt_q != 3'd0) begin
                    tune_vld_q <= 1'b1;
                    tune_q     <= tune_d;
                end
                buf_q <= '0;
                cnt_q <= '0;
            end
        end
    end

    assign bus.note_vld = note_vld_q;
    assign bus.note     = note_q;
    assign bus.note_dur = note_dur_q;
    assign bus.tune_vld = tune_vld_q;
    assign bus.tune     = tune_q;
    assign bus.diff_err = diff_err_q;

endmodule

// File: tb/tb_piezo_rx.sv
// Directed bench for piezo_rx using scaled-down note periods (32/24/19/16, TOL 1, silence 100).
module tb_piezo_rx;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_tests;
    int   n_fail;

    piezo_rx_if bus ();

    piezo_rx #(
        .G6_PER(32), .C7_PER(24), .E7_PER(19), .G7_PER(16), .TOL(1), .SIL_LEN(100)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0]  nq_code[$];
    logic [24:0] nq_dur[$];
    int          nq_cyc[$];
    logic [1:0]  tq_code[$];
    int          tq_cyc[$];

    always @(negedge clk) begin
        if (bus.note_vld === 1'b1) begin
            nq_code.push_back(bus.note);
            nq_dur.push_back(bus.note_dur);
            nq_cyc.push_back(cyc);
        end
        if (bus.tune_vld === 1'b1) begin
            tq_code.push_back(bus.tune);
            tq_cyc.push_back(cyc);
        end
    end

    function automatic int per_of(input logic [1:0] code);
        case (code)
            2'd0: return 32;
            2'd1: return 24;
            2'd2: return 19;
            default: return 16;
        endcase
    endfunction

    task automatic clear_q();
        nq_code.delete(); nq_dur.delete(); nq_cyc.delete();
        tq_code.delete(); tq_cyc.delete();
    endtask

    // One rise followed by p cycles before the next call's rise.
    task automatic period(input int p);
        bus.piezo = 1'b1; bus.piezo_n = 1'b0;
        repeat (p / 2) @(negedge clk);
        bus.piezo = 1'b0; bus.piezo_n = 1'b1;
        repeat (p - p / 2) @(negedge clk);
    endtask

    task automatic run(input int p, input int n);
        repeat (n) period(p);
    endtask

    // Closing rise, then enough quiet for silence plus the tune pulse.
    task automatic close_tone();
        bus.piezo = 1'b1; bus.piezo_n = 1'b0;
        repeat (4) @(negedge clk);
        bus.piezo = 1'b0; bus.piezo_n = 1'b1;
        repeat (150) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.piezo = 1'b0; bus.piezo_n = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++; if (bus.note_vld !== 1'b0) begin n_fail++; $display("FAIL reset_note_vld: got %b, expected 0", bus.note_vld); end
        n_tests++; if (bus.note !== 2'd0) begin n_fail++; $display("FAIL reset_note: got %0d, expected 0", bus.note); end
        n_tests++; if (bus.note_dur !== 25'd0) begin n_fail++; $display("FAIL reset_note_dur: got %0d, expected 0", bus.note_dur); end
        n_tests++; if (bus.tune_vld !== 1'b0) begin n_fail++; $display("FAIL reset_tune_vld: got %b, expected 0", bus.tune_vld); end
        n_tests++; if (bus.tune !== 2'd0) begin n_fail++; $display("FAIL reset_tune: got %0d, expected 0", bus.tune); end
        n_tests++; if (bus.diff_err !== 1'b0) begin n_fail++; $display("FAIL reset_diff_err: got %b, expected 0", bus.diff_err); end
        rst_n = 1'b1;
        repeat (120) @(negedge clk);
        n_tests++; if (nq_code.size() != 0 || tq_code.size() != 0) begin n_fail++; $display("FAIL idle_pulses: got %0d notes %0d tunes, expected 0 0", nq_code.size(), tq_code.size()); end
    endtask

    // Ten pulses 24 cycles apart: nine tracked C7 periods.
    task automatic test_single_note();
        clear_q();
        run(24, 9);
        close_tone();
        n_tests++; if (nq_code.size() != 1) begin n_fail++; $display("FAIL single_note_count: got %0d, expected 1", nq_code.size()); end
        if (nq_code.size() >= 1) begin
            n_tests++; if (nq_code[0] !== 2'd1) begin n_fail++; $display("FAIL single_note_code: got %0d, expected 1", nq_code[0]); end
            n_tests++; if (nq_dur[0] !== 25'd216) begin n_fail++; $display("FAIL single_note_dur: got %0d, expected 216", nq_dur[0]); end
        end
        n_tests++; if (tq_code.size() != 1) begin n_fail++; $display("FAIL single_tune_count: got %0d, expected 1", tq_code.size()); end
        if (tq_code.size() >= 1 && nq_cyc.size() >= 1) begin
            n_tests++; if (tq_code[0] !== 2'd0) begin n_fail++; $display("FAIL single_tune_code: got %0d, expected 0", tq_code[0]); end
            n_tests++; if (tq_cyc[0] != nq_cyc[0] + 1) begin n_fail++; $display("FAIL tune_latency: got %0d, expected %0d", tq_cyc[0] - nq_cyc[0], 1); end
        end
    endtask

    task automatic test_tune(input string name, input logic [11:0] seq, input int n, input logic [1:0] exp_tune);
        logic [1:0] c;
        clear_q();
        for (int i = 0; i < n; i++) begin
            c = seq[2*(n-1-i) +: 2];
            run(per_of(c), 8);
        end
        close_tone();
        n_tests++; if (nq_code.size() != n) begin n_fail++; $display("FAIL %s_note_count: got %0d, expected %0d", name, nq_code.size(), n); end
        for (int i = 0; i < n && i < nq_code.size(); i++) begin
            c = seq[2*(n-1-i) +: 2];
            n_tests++; if (nq_code[i] !== c) begin n_fail++; $display("FAIL %s_note%0d: got %0d, expected %0d", name, i, nq_code[i], c); end
        end
        if (nq_dur.size() == n) begin
            n_tests++; if (nq_dur[n-1] !== 25'(8 * per_of(seq[1:0]))) begin n_fail++; $display("FAIL %s_last_dur: got %0d, expected %0d", name, nq_dur[n-1], 8 * per_of(seq[1:0])); end
        end
        n_tests++; if (tq_code.size() != 1) begin n_fail++; $display("FAIL %s_tune_count: got %0d, expected 1", name, tq_code.size()); end
        else begin
            n_tests++; if (tq_code[0] !== exp_tune) begin n_fail++; $display("FAIL %s_tune: got %0d, expected %0d", name, tq_code[0], exp_tune); end
        end
    endtask

    task automatic test_tolerance();
        clear_q();
        repeat (4) begin period(33); period(31); end
        close_tone();
        n_tests++; if (nq_code.size() != 1) begin n_fail++; $display("FAIL tol_note_count: got %0d, expected 1", nq_code.size()); end
        if (nq_code.size() == 1) begin
            n_tests++; if (nq_code[0] !== 2'd0) begin n_fail++; $display("FAIL tol_note_code: got %0d, expected 0", nq_code[0]); end
            n_tests++; if (nq_dur[0] !== 25'd256) begin n_fail++; $display("FAIL tol_note_dur: got %0d, expected 256", nq_dur[0]); end
        end
    endtask

    task automatic test_invalid_period();
        clear_q();
        run(24, 5);
        period(28);
        run(24, 5);
        close_tone();
        n_tests++; if (nq_code.size() != 2) begin n_fail++; $display("FAIL inval_note_count: got %0d, expected 2", nq_code.size()); end
        if (nq_code.size() == 2) begin
            n_tests++; if (nq_code[0] !== 2'd1 || nq_code[1] !== 2'd1) begin n_fail++; $display("FAIL inval_codes: got %0d %0d, expected 1 1", nq_code[0], nq_code[1]); end
            n_tests++; if (nq_dur[1] !== 25'd120) begin n_fail++; $display("FAIL inval_second_dur: got %0d, expected 120", nq_dur[1]); end
        end
        n_tests++; if (tq_code.size() != 1 || (tq_code.size() == 1 && tq_code[0] !== 2'd0)) begin n_fail++; $display("FAIL inval_tune: got %0d pulses, expected one with code 0", tq_code.size()); end
    endtask

    task automatic test_diff_err();
        n_tests++; if (bus.diff_err !== 1'b0) begin n_fail++; $display("FAIL diff_err_before: got %b, expected 0", bus.diff_err); end
        bus.piezo = 1'b1; bus.piezo_n = 1'b1;
        repeat (3) @(negedge clk);
        bus.piezo = 1'b0; bus.piezo_n = 1'b1;
        repeat (10) @(negedge clk);
        n_tests++; if (bus.diff_err !== 1'b1) begin n_fail++; $display("FAIL diff_err_set: got %b, expected 1", bus.diff_err); end
        repeat (150) @(negedge clk);
        n_tests++; if (bus.diff_err !== 1'b1) begin n_fail++; $display("FAIL diff_err_sticky: got %b, expected 1", bus.diff_err); end
    endtask

    task automatic test_reset_mid_note();
        clear_q();
        run(32, 5);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++; if ({bus.note_vld, bus.note, bus.note_dur, bus.tune_vld, bus.tune, bus.diff_err} !== '0) begin n_fail++; $display("FAIL midreset_outputs: got %b/%0d/%0d/%b/%0d/%b, expected all 0", bus.note_vld, bus.note, bus.note_dur, bus.tune_vld, bus.tune, bus.diff_err); end
        rst_n = 1'b1;
        repeat (150) @(negedge clk);
        n_tests++; if (nq_code.size() != 0 || tq_code.size() != 0) begin n_fail++; $display("FAIL midreset_pulses: got %0d notes %0d tunes, expected 0 0", nq_code.size(), tq_code.size()); end
        test_tune("post_reset_fast", 12'b00_01_10, 3, 2'b10);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0; bus.piezo = 1'b0; bus.piezo_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_single_note();
        test_tune("steer", 12'b00_01_10_11_10_11, 6, 2'b01);
        test_tune("fast",  12'b00_01_10,          3, 2'b10);
        test_tune("batt",  12'b11_10_11_10_01_00, 6, 2'b11);
        test_tolerance();
        test_invalid_period();
        test_diff_err();
        test_reset_mid_note();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
